// File: rtl/useq_pkg.sv
// rtl/useq_pkg.sv - shared op encoding and default sizes for the microsequencer
package useq_pkg;

    localparam int USEQ_AW    = 12;
    localparam int USEQ_DEPTH = 4;
    localparam int USEQ_NCOND = 8;
    localparam int USEQ_CW    = 8;

    // Values 6 and 7 are unnamed and decode as NEXT.
    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_JUMP = 3'd1,
        OP_CALL = 3'd2,
        OP_RET  = 3'd3,
        OP_MAP  = 3'd4,
        OP_LOOP = 3'd5
    } useq_op_e;

endpackage

// File: rtl/useq_stack.sv
// rtl/useq_stack.sv - return-address LIFO for the microsequencer
// Ports: clock, reset (async, active high); push/pop requests with push_data;
// top is the most recent entry; full/empty report occupancy.
// Overflowing pushes and underflowing pops are ignored here; the caller flags them.
module useq_stack #(
    parameter int AW    = 12,
    parameter int DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] push_data,
    output logic [AW-1:0] top,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] sp;
    logic [PW-2:0] top_idx;

    assign full    = (sp == PW'(DEPTH));
    assign empty   = (sp == '0);
    // Low bits wrap so a full stack (sp == DEPTH) still points at DEPTH-1.
    assign top_idx = sp[PW-2:0] - 1'b1;
    assign top     = mem[top_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end

    // Entry contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (push && !full && !reset) begin
            mem[sp[PW-2:0]] <= push_data;
        end
    end

endmodule

// File: rtl/useq_engine.sv
// rtl/useq_engine.sv - microprogram sequencer with call stack and loop counter
// Ports: clock, reset (async, active high), stall holds all state;
// op/cond_sel/cond_invert/conditions select the next-address rule;
// d_in target, map_in dispatch, count_load/count_in load the loop counter;
// address is the registered upc, count_zero, sticky stack_overflow/underflow.
module useq_engine
    import useq_pkg::*;
#(
    parameter int AW    = USEQ_AW,
    parameter int DEPTH = USEQ_DEPTH,
    parameter int NCOND = USEQ_NCOND,
    parameter int CW    = USEQ_CW
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     stall,
    input  logic [2:0]               op,
    input  logic [$clog2(NCOND)-1:0] cond_sel,
    input  logic                     cond_invert,
    input  logic [NCOND-1:0]         conditions,
    input  logic [AW-1:0]            d_in,
    input  logic [AW-1:0]            map_in,
    input  logic                     count_load,
    input  logic [CW-1:0]            count_in,
    output logic [AW-1:0]            address,
    output logic                     count_zero,
    output logic                     stack_overflow,
    output logic                     stack_underflow
);

    useq_op_e      op_dec;
    logic [AW-1:0] upc;
    logic [AW-1:0] upc_inc;
    logic [AW-1:0] upc_next;
    logic [AW-1:0] stack_top;
    logic [CW-1:0] count;
    logic          cond;
    logic          loop_taken;
    logic          stack_full;
    logic          stack_empty;
    logic          push;
    logic          pop;
    logic          set_ovf;
    logic          set_udf;

    assign op_dec     = useq_op_e'(op);
    assign cond       = conditions[cond_sel] ^ cond_invert;
    assign upc_inc    = upc + 1'b1;
    assign loop_taken = (count != '0);
    assign address    = upc;
    assign count_zero = (count == '0);

    always_comb begin
        upc_next = upc_inc;
        push     = 1'b0;
        pop      = 1'b0;
        set_ovf  = 1'b0;
        set_udf  = 1'b0;
        case (op_dec)
            OP_JUMP: if (cond) upc_next = d_in;
            OP_CALL: begin
                if (cond) begin
                    // A full stack still takes the jump; only the push is lost.
                    upc_next = d_in;
                    if (stack_full) set_ovf = 1'b1;
                    else            push    = 1'b1;
                end
            end
            OP_RET: begin
                if (cond) begin
                    if (stack_empty) begin
                        upc_next = '0;
                        set_udf  = 1'b1;
                    end else begin
                        upc_next = stack_top;
                        pop      = 1'b1;
                    end
                end
            end
            OP_MAP:  upc_next = map_in;
            OP_LOOP: if (loop_taken) upc_next = d_in;
            default: ;
        endcase
    end

    useq_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clock     (clock),
        .reset     (reset),
        .push      (push && !stall),
        .pop       (pop && !stall),
        .push_data (upc_inc),
        .top       (stack_top),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            upc             <= '0;
            count           <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else if (!stall) begin
            upc             <= upc_next;
            stack_overflow  <= stack_overflow | set_ovf;
            stack_underflow <= stack_underflow | set_udf;
            // A load wins over the decrement; the branch above used the old count.
            if (count_load) begin
                count <= count_in;
            end else if (op_dec == OP_LOOP && loop_taken) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule
